apb_rmw_master: RTL and testbench

APB_RMW_MASTER -- requirements
Module: apb_rmw_master

---
 rtl/apb_rmw_master.sv | 177 +++++++++++++++++
 tb/tb_apb_rmw_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rmw_master.sv
// APB master executing single READ / WRITE / RMW-ADD commands with a per-phase
// ACCESS timeout. One command in flight at a time; a one-cycle response pulse
// reports read data and error status.
module apb_rmw_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16   // legal range 1..255
) (
    input  logic              pclk,
    input  logic              preset_n,
    // Command channel
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    // Response channel
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    // APB master port
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    localparam logic [1:0] OpNop   = 2'b00;
    localparam logic [1:0] OpWrite = 2'b10;
    localparam logic [1:0] OpRmw   = 2'b11;

    // Counter value seen in the last permitted ACCESS cycle of a phase.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;      // addend for RMW-ADD
    logic [DATA_W-1:0]   wdata_q, wdata_d;    // data driven on pwdata_o
    logic                wr_q, wr_d;          // current phase is a write
    logic [DATA_W-1:0]   rdata_q, rdata_d;    // RMW original read value
    logic [7:0]          cnt_q, cnt_d;        // ACCESS cycles in current phase
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic                in_xfer;

    // State and datapath registers, cleared asynchronously by preset_n.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= StIdle;
            op_q          <= OpNop;
            addr_q        <= '0;
            data_q        <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            wdata_q       <= wdata_d;
            wr_q          <= wr_d;
            rdata_q       <= rdata_d;
            cnt_q         <= cnt_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state logic: command capture, phase sequencing, timeout and response update.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        wdata_d       = wdata_q;
        wr_d          = wr_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                // NOP handshakes complete here with no further effect.
                if (cmd_valid_i && (cmd_op_i != OpNop)) begin
                    op_d    = cmd_op_i;
                    addr_d  = cmd_addr_i;
                    data_d  = cmd_data_i;
                    wdata_d = cmd_data_i;
                    wr_d    = (cmd_op_i == OpWrite);
                    rdata_d = '0;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end

            StAccess: begin
                if (pready_i) begin
                    if (!wr_q) begin
                        rdata_d = prdata_i;
                    end
                    if ((op_q == OpRmw) && !wr_q && !pslverr_i) begin
                        // Read phase succeeded: start the write-back phase.
                        wdata_d = prdata_i + data_q;
                        wr_d    = 1'b1;
                        state_d = StSetup;
                    end else begin
                        // A write phase reached here only after a clean read,
                        // so this phase's slave error is the OR of all phases.
                        if (op_q == OpWrite) begin
                            rsp_rdata_d = '0;
                        end else if (!wr_q) begin
                            rsp_rdata_d = prdata_i;
                        end else begin
                            rsp_rdata_d = rdata_q;
                        end
                        rsp_err_d     = pslverr_i;
                        rsp_timeout_d = 1'b0;
                        state_d       = StResp;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus and handshake outputs decoded from the state; address/data gated to 0 outside a transfer.
    always_comb begin
        in_xfer       = (state_q == StSetup) || (state_q == StAccess);
        cmd_ready_o   = (state_q == StIdle);
        psel_o        = in_xfer;
        penable_o     = (state_q == StAccess);
        pwrite_o      = in_xfer && wr_q;
        paddr_o       = in_xfer ? addr_q : '0;
        pwdata_o      = (in_xfer && wr_q) ? wdata_q : '0;
        rsp_valid_o   = (state_q == StResp);
        rsp_rdata_o   = rsp_rdata_q;
        rsp_err_o     = rsp_err_q;
        rsp_timeout_o = rsp_timeout_q;
    end

endmodule

// File: tb/tb_apb_rmw_master.sv
// Directed bench for apb_rmw_master: a scoreboard of expected responses, a
// configurable APB slave and bus-activity counters, checked with immediate assertions.
module tb_apb_rmw_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_data_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic [DW-1:0] prdata_i = '0;
    logic          pready_i = 1'b0;
    logic          pslverr_i = 1'b0;

    apb_rmw_master #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(4)
    ) dut (
        .pclk         (pclk),
        .preset_n     (preset_n),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_data_i   (cmd_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tout;
        int          lat;
        bit          chk_rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rsp_cnt = 0;

    // Bus monitor counters
    int psel_cnt, pen_cnt, wr_cnt, wdata_ok_cnt, addr_bad, acc_run;
    logic [31:0] exp_addr, exp_pwdata;

    // Slave configuration
    int          ws;
    bit          hang;
    bit          s_err;
    logic [31:0] s_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] r, input logic er, input logic t, input int l,
                            input bit c);
        exp_t x;
        x.rdata     = r;
        x.err       = er;
        x.tout      = t;
        x.lat       = l;
        x.chk_rdata = c;
        sb_q.push_back(x);
    endtask

    // Present a command for one edge, then scramble the inputs to prove they were latched.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = a;
        cmd_data_i  = d;
        tick();
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'($urandom);
        cmd_addr_i  = $urandom;
        cmd_data_i  = $urandom;
    endtask

    task automatic clr_mon();
        psel_cnt     = 0;
        pen_cnt      = 0;
        wr_cnt       = 0;
        wdata_ok_cnt = 0;
        addr_bad     = 0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 60) begin
            tick();
            n++;
        end
        check("rsp_count", 64'(rsp_cnt), 64'(target));
    endtask

    // Cycle counter; records the acceptance edge of each real command.
    always @(posedge pclk) begin
        if (preset_n && cmd_valid_i && cmd_ready_o && cmd_op_i != 2'b00) acc_cyc = cyc;
        cyc++;
    end

    // Response scoreboard, bus monitor and APB slave model.
    always @(negedge pclk) begin
        if (preset_n && rsp_valid_o) begin
            rsp_cnt++;
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
            end else begin
                e = sb_q.pop_front();
                if (e.chk_rdata) check("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                check("rsp_timeout", 64'(rsp_timeout_o), 64'(e.tout));
                check("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
            end
        end
        if (psel_o) begin
            psel_cnt++;
            if (paddr_o !== exp_addr) addr_bad++;
            if (pwrite_o) begin
                wr_cnt++;
                if (pwdata_o === exp_pwdata) wdata_ok_cnt++;
            end
        end
        if (psel_o && penable_o) begin
            pen_cnt++;
            pready_i  = !hang && (acc_run == ws);
            pslverr_i = pready_i && s_err;
            prdata_i  = s_rdata;
            acc_run++;
        end else begin
            pready_i  = 1'b0;
            pslverr_i = 1'b0;
            prdata_i  = 32'hDEAD_BEEF;
            acc_run   = 0;
        end
    end

    initial begin
        int n;
        preset_n    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'b00;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        hang        = 1'b0;
        s_err       = 1'b0;
        ws          = 0;
        s_rdata     = '0;
        exp_addr    = '0;
        exp_pwdata  = '0;
        clr_mon();

        // Reset values
        #1 preset_n = 1'b0;
        #1;
        check("rst_psel", 64'(psel_o), 64'(0));
        check("rst_penable", 64'(penable_o), 64'(0));
        check("rst_pwrite", 64'(pwrite_o), 64'(0));
        check("rst_paddr", 64'(paddr_o), 64'(0));
        check("rst_pwdata", 64'(pwdata_o), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_rsp_err", 64'(rsp_err_o), 64'(0));
        check("rst_rsp_timeout", 64'(rsp_timeout_o), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
        tick();
        tick();
        preset_n = 1'b1;
        tick();
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'(1));

        // READ, zero wait states
        clr_mon();
        exp_addr = 32'hA000; ws = 0; s_rdata = 32'h1234;
        push_exp(32'h1234, 1'b0, 1'b0, 3, 1'b1);
        send(2'b01, 32'hA000, 32'h0);
        wait_rsp(1);
        check("read_psel_cycles", 64'(psel_cnt), 64'(2));
        check("read_penable_cycles", 64'(pen_cnt), 64'(1));
        check("read_addr_stable", 64'(addr_bad), 64'(0));
        check("read_no_pwrite", 64'(wr_cnt), 64'(0));
        tick();
        tick();
        check("rsp_hold_rdata", 64'(rsp_rdata_o), 64'(32'h1234));
        check("rsp_pulse_once", 64'(rsp_cnt), 64'(1));

        // WRITE with two wait states
        clr_mon();
        exp_addr = 32'hA004; exp_pwdata = 32'h55; ws = 2;
        push_exp(32'h0, 1'b0, 1'b0, 5, 1'b1);
        send(2'b10, 32'hA004, 32'h55);
        wait_rsp(2);
        check("write_penable_cycles", 64'(pen_cnt), 64'(3));
        check("write_pwdata_held", 64'(wdata_ok_cnt), 64'(4));
        check("write_addr_stable", 64'(addr_bad), 64'(0));

        // RMW-ADD with carry out discarded
        clr_mon();
        exp_addr = 32'hA000; exp_pwdata = 32'h0; ws = 0; s_rdata = 32'hFFFF_FFFF;
        push_exp(32'hFFFF_FFFF, 1'b0, 1'b0, 5, 1'b1);
        send(2'b11, 32'hA000, 32'h1);
        wait_rsp(3);
        check("rmw_psel_cycles", 64'(psel_cnt), 64'(4));
        check("rmw_write_cycles", 64'(wr_cnt), 64'(2));
        check("rmw_wrap_pwdata", 64'(wdata_ok_cnt), 64'(2));
        check("rmw_addr_stable", 64'(addr_bad), 64'(0));

        // RMW-ADD ordinary sum with one wait state per phase
        clr_mon();
        exp_addr = 32'hA020; exp_pwdata = 32'h32; ws = 1; s_rdata = 32'h10;
        push_exp(32'h10, 1'b0, 1'b0, 7, 1'b1);
        send(2'b11, 32'hA020, 32'h22);
        wait_rsp(4);
        check("rmw_sum_pwdata", 64'(wdata_ok_cnt), 64'(3));
        check("rmw_sum_penable", 64'(pen_cnt), 64'(4));

        // NOP is consumed silently
        clr_mon();
        ws = 0;
        send(2'b00, 32'hA008, 32'h0);
        repeat (4) tick();
        check("nop_no_apb", 64'(psel_cnt), 64'(0));
        check("nop_no_rsp", 64'(rsp_cnt), 64'(4));

        // READ timeout with TIMEOUT=4
        clr_mon();
        exp_addr = 32'hA00C; hang = 1'b1;
        push_exp(32'h0, 1'b1, 1'b1, 6, 1'b1);
        send(2'b01, 32'hA00C, 32'h0);
        wait_rsp(5);
        check("tmo_penable_cycles", 64'(pen_cnt), 64'(4));
        hang = 1'b0;

        // RMW-ADD with slave error on the read phase
        clr_mon();
        exp_addr = 32'hA010; s_err = 1'b1; s_rdata = 32'h77;
        push_exp(32'h77, 1'b1, 1'b0, 3, 1'b0);
        send(2'b11, 32'hA010, 32'h5);
        wait_rsp(6);
        check("rmwerr_no_write", 64'(wr_cnt), 64'(0));
        check("rmwerr_penable", 64'(pen_cnt), 64'(1));
        s_err = 1'b0;

        // Reset asserted during ACCESS
        clr_mon();
        exp_addr = 32'hA014; hang = 1'b1;
        send(2'b01, 32'hA014, 32'h0);
        n = 0;
        while (!penable_o && n < 10) begin
            tick();
            n++;
        end
        check("rstacc_reached", 64'(penable_o), 64'(1));
        #2 preset_n = 1'b0;
        #1;
        check("rstacc_psel", 64'(psel_o), 64'(0));
        check("rstacc_penable", 64'(penable_o), 64'(0));
        check("rstacc_paddr", 64'(paddr_o), 64'(0));
        repeat (3) tick();
        preset_n = 1'b1;
        hang = 1'b0;
        tick();
        check("rstacc_no_rsp", 64'(rsp_cnt), 64'(6));

        // Normal READ after reset
        clr_mon();
        exp_addr = 32'hA018; s_rdata = 32'hBEEF;
        push_exp(32'hBEEF, 1'b0, 1'b0, 3, 1'b1);
        send(2'b01, 32'hA018, 32'h0);
        wait_rsp(7);
        check("post_rst_psel", 64'(psel_cnt), 64'(2));

        tick();
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
